// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle IF/ID/EX/MEM/WB control unit with cycle and retire counters
//
// Latches the fetched instruction on the edge leaving IF, decodes it from the
// latched copy, and steps a five-state FSM. The control word and register-file
// write controls are combinational functions of the state, the latched
// instruction and, in EX only, the router comparison flags.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   asynchronous active-high reset
//   instr    in  32   instruction word from IM, valid during IF
//   b        in   2   router flags: b[1]=eql (rs==rt), b[0]=ltz (rs[31])
//   op       out 13   {ifup[12:10], alup[9:4], dmp[3:1], dme[0]}
//   rf_we    out  1   register-file write enable
//   rf_a3    out  5   register-file write address
//   state    out  3   IF=0, ID=1, EX=2, MEM=3, WB=4
//   retire   out  1   pulse in the final state of each instruction
//   cyc_cnt  out 32   clock edges since reset
//   ret_cnt  out 32   instructions retired since reset

module mc_ctrl #(
    parameter logic [31:0] RST_PC_CNT = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [1:0]  b,
    output logic [12:0] op,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [2:0]  state,
    output logic        retire,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Instruction classes; nop and every unrecognised encoding share C_NOP
    // because they follow the same IF-ID sequence with pc+4.
    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW,
        C_BEQ, C_BLTZ, C_J, C_JR, C_JAL
    } iclass_t;

    state_t        state_q, state_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   cyc_q, cyc_d;
    logic [31:0]   ret_q, ret_d;

    iclass_t       cls;
    logic [5:0]    opc;
    logic [5:0]    funct;
    logic [2:0]    ifup;
    logic [5:0]    alup;
    logic [2:0]    dmp;
    logic          dme;
    logic [4:0]    a3_dec;
    logic          fin;

    assign opc   = ir_q[31:26];
    assign funct = ir_q[5:0];

    // Decode from the latched instruction only.
    always_comb begin
        cls = C_NOP;
        if (ir_q != 32'd0) begin
            case (opc)
                6'b000000: begin
                    case (funct)
                        6'b100001: cls = C_ADDU;
                        6'b100011: cls = C_SUBU;
                        6'b001000: cls = C_JR;
                        default:   cls = C_NOP;
                    endcase
                end
                6'b001101: cls = C_ORI;
                6'b001111: cls = C_LUI;
                6'b100011: cls = C_LW;
                6'b101011: cls = C_SW;
                6'b000100: cls = C_BEQ;
                6'b000001: cls = (ir_q[20:16] == 5'd0) ? C_BLTZ : C_NOP;
                6'b000010: cls = C_J;
                6'b000011: cls = C_JAL;
                default:   cls = C_NOP;
            endcase
        end
    end

    // Per-class datapath selections that hold from EX through the final state.
    always_comb begin
        alup   = 6'd0;
        dmp    = 3'd0;
        a3_dec = 5'd0;
        case (cls)
            C_ADDU: begin alup = 6'b000001; a3_dec = ir_q[15:11]; end
            C_SUBU: begin alup = 6'b000010; a3_dec = ir_q[15:11]; end
            C_ORI:  begin alup = 6'b000100; a3_dec = ir_q[20:16]; end
            C_LUI:  begin alup = 6'b001000; a3_dec = ir_q[20:16]; end
            C_LW:   begin alup = 6'b000001; dmp = 3'b001; a3_dec = ir_q[20:16]; end
            C_SW:   begin alup = 6'b000001; dmp = 3'b010; end
            C_JAL:  begin alup = 6'b100000; a3_dec = 5'd31; end
            default: ;
        endcase
    end

    // Next state and final-state detection.
    always_comb begin
        state_d = S_IF;
        fin     = 1'b0;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (cls == C_NOP) fin = 1'b1;
                else              state_d = S_EX;
            end
            S_EX: begin
                case (cls)
                    C_BEQ, C_BLTZ, C_J, C_JR: fin = 1'b1;
                    C_LW, C_SW:               state_d = S_MEM;
                    default:                  state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (cls == C_LW) state_d = S_WB;
                else             fin = 1'b1;
            end
            S_WB: fin = 1'b1;
            default: state_d = S_IF;  // illegal encodings fall back to fetch
        endcase
    end

    // PC-update selection, only meaningful in the final state. Branch flags
    // are consulted only when the branch resolves in EX.
    always_comb begin
        ifup = 3'd0;
        if (fin) begin
            case (cls)
                C_BEQ:       ifup = b[1] ? 3'd2 : 3'd1;
                C_BLTZ:      ifup = b[0] ? 3'd2 : 3'd1;
                C_J, C_JAL:  ifup = 3'd3;
                C_JR:        ifup = 3'd4;
                default:     ifup = 3'd1;
            endcase
        end
    end

    always_comb begin
        op     = 13'd0;
        rf_we  = 1'b0;
        rf_a3  = 5'd0;
        dme    = 1'b0;
        if (state_q == S_MEM && cls == C_SW) dme = 1'b1;
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB)
            op = {ifup, alup, dmp, dme};
        else
            op = {ifup, 6'd0, 3'd0, 1'b0};
        if (state_q == S_WB) begin
            rf_a3 = a3_dec;
            rf_we = (a3_dec != 5'd0);
        end
    end

    assign retire  = fin;
    assign state   = state_q;
    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;

    always_comb begin
        ir_d  = ir_q;
        if (state_q == S_IF) ir_d = instr;
        cyc_d = cyc_q + 32'd1;
        ret_d = ret_q + {31'd0, fin};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            ir_q    <= 32'd0;
            cyc_q   <= RST_PC_CNT;
            ret_q   <= RST_PC_CNT;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed and randomized self-checking bench for mc_ctrl

module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic [1:0]  b = 2'd0;
    logic [12:0] op;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [2:0]  state;
    logic        retire;
    logic [31:0] cyc_cnt;
    logic [31:0] ret_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_cyc = 32'd0;
    logic [31:0] exp_ret = 32'd0;

    localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_ORI = 3, K_LUI = 4, K_LW = 5,
                   K_SW = 6, K_BEQ = 7, K_BLTZ = 8, K_J = 9, K_JR = 10, K_JAL = 11;

    mc_ctrl #(.RST_PC_CNT(32'd0)) dut (
        .clk(clk), .rst(rst), .instr(instr), .b(b), .op(op), .rf_we(rf_we),
        .rf_a3(rf_a3), .state(state), .retire(retire), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Instruction kind from the ISA field rules.
    function automatic int kind_of(input logic [31:0] w);
        logic [5:0] o, f;
        o = w[31:26];
        f = w[5:0];
        if (w == 32'd0) return K_NOP;
        if (o == 6'd0) begin
            if (f == 6'h21) return K_ADDU;
            if (f == 6'h23) return K_SUBU;
            if (f == 6'h08) return K_JR;
            return K_NOP;
        end
        if (o == 6'h0D) return K_ORI;
        if (o == 6'h0F) return K_LUI;
        if (o == 6'h23) return K_LW;
        if (o == 6'h2B) return K_SW;
        if (o == 6'h04) return K_BEQ;
        if (o == 6'h01) return (w[20:16] == 5'd0) ? K_BLTZ : K_NOP;
        if (o == 6'h02) return K_J;
        if (o == 6'h03) return K_JAL;
        return K_NOP;
    endfunction

    // Runs one instruction through its whole state sequence, checking every
    // cycle. bsel<0 gives random flags. abort_idx>=0 asserts reset in that
    // step of the sequence instead of finishing it.
    task automatic run_instr(input logic [31:0] iw, input int bsel, input int abort_idx,
                             output int len);
        int k;
        int seq[$];
        logic [2:0] ifup_e;
        logic [5:0] alup_e;
        logic [2:0] dmp_e;
        logic       dme_e;
        logic [4:0] a3_e;
        logic       last;
        k = kind_of(iw);
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI, K_JAL: seq = '{0, 1, 2, 4};
            K_LW:                               seq = '{0, 1, 2, 3, 4};
            K_SW:                               seq = '{0, 1, 2, 3};
            K_BEQ, K_BLTZ, K_J, K_JR:           seq = '{0, 1, 2};
            default:                            seq = '{0, 1};
        endcase
        len = seq.size();
        alup_e = (k == K_ADDU || k == K_LW || k == K_SW) ? 6'd1 :
                 (k == K_SUBU) ? 6'd2 : (k == K_ORI) ? 6'd4 :
                 (k == K_LUI) ? 6'd8 : (k == K_JAL) ? 6'd32 : 6'd0;
        dmp_e  = (k == K_LW) ? 3'd1 : (k == K_SW) ? 3'd2 : 3'd0;
        a3_e   = (k == K_ADDU || k == K_SUBU) ? iw[15:11] :
                 (k == K_ORI || k == K_LUI || k == K_LW) ? iw[20:16] :
                 (k == K_JAL) ? 5'd31 : 5'd0;
        for (int i = 0; i < len; i++) begin
            // instr is garbage outside IF so decode must rely on the latched word
            instr = (seq[i] == 0) ? iw : $urandom;
            b = (bsel < 0) ? 2'($urandom_range(0, 3)) : 2'(bsel);
            #1;
            last = (i == len - 1);
            ifup_e = 3'd0;
            if (last) begin
                case (k)
                    K_BEQ:        ifup_e = b[1] ? 3'd2 : 3'd1;
                    K_BLTZ:       ifup_e = b[0] ? 3'd2 : 3'd1;
                    K_J, K_JAL:   ifup_e = 3'd3;
                    K_JR:         ifup_e = 3'd4;
                    default:      ifup_e = 3'd1;
                endcase
            end
            dme_e = (seq[i] == 3 && k == K_SW);
            chk("state", 32'(state), 32'(seq[i]));
            chk("op", 32'(op), 32'({ifup_e, (seq[i] >= 2) ? alup_e : 6'd0,
                                    (seq[i] >= 2) ? dmp_e : 3'd0, dme_e}));
            chk("rf_a3", 32'(rf_a3), 32'((seq[i] == 4) ? a3_e : 5'd0));
            chk("rf_we", 32'(rf_we), 32'(seq[i] == 4 && a3_e != 5'd0));
            chk("retire", 32'(retire), 32'(last));
            chk("cyc_cnt", cyc_cnt, exp_cyc);
            chk("ret_cnt", ret_cnt, exp_ret);
            if (i == abort_idx) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_state", 32'(state), 32'd0);
                chk("rst_op", 32'(op), 32'd0);
                chk("rst_rf_we", 32'(rf_we), 32'd0);
                chk("rst_rf_a3", 32'(rf_a3), 32'd0);
                chk("rst_retire", 32'(retire), 32'd0);
                chk("rst_cyc", cyc_cnt, 32'd0);
                chk("rst_ret", ret_cnt, 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                exp_cyc = 32'd0;
                exp_ret = 32'd0;
                return;
            end
            if (last) exp_ret++;
            exp_cyc++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  return {6'd0, r[25:6], 6'h21};
            1:  return {6'd0, r[25:6], 6'h23};
            2:  return {6'd0, r[25:6], 6'h08};
            3:  return {6'h0D, r[25:0]};
            4:  return {6'h0F, r[25:0]};
            5:  return {6'h23, r[25:0]};
            6:  return {6'h2B, r[25:0]};
            7:  return {6'h04, r[25:0]};
            8:  return {6'h01, r[25:21], 5'd0, r[15:0]};
            9:  return {6'h01, r[25:0]};
            10: return {6'h02, r[25:0]};
            11: return {6'h03, r[25:0]};
            12: return 32'd0;
            default: return r;
        endcase
    endfunction

    initial begin
        int n;
        int sum;
        logic [31:0] start_cyc;
        @(negedge clk);
        rst = 1'b0;
        // lw aborted by reset in EX
        run_instr(32'h8C880004, -1, 2, n);
        run_instr(32'h00851021, -1, -1, n);
        chk("addu_len", 32'(n), 32'd4);
        chk("addu_ret", ret_cnt, 32'd1);
        run_instr(32'h8C880004, -1, -1, n);
        chk("lw_len", 32'(n), 32'd5);
        run_instr(32'hAC880004, -1, -1, n);
        run_instr(32'h10850003, 2, -1, n);
        run_instr(32'h10850003, 1, -1, n);
        run_instr(32'h0C000C00, -1, -1, n);
        run_instr(32'h34000005, -1, -1, n);
        run_instr(32'hFC000000, -1, -1, n);
        run_instr(32'h00000000, -1, -1, n);
        run_instr(32'h04000010, 1, -1, n);
        run_instr(32'h04000010, 2, -1, n);
        run_instr(32'h03E00008, -1, -1, n);
        #1;
        start_cyc = cyc_cnt;
        sum = 0;
        for (int i = 0; i < 100; i++) begin
            run_instr(rand_instr(), -1, -1, n);
            sum += n;
        end
        #1;
        chk("stream_cyc", cyc_cnt - start_cyc, 32'(sum));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
